// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, supported opcodes
// and the datapath mux/ALU code values driven by the output decoder.
package mc_control_pkg;

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MADDR = 4'd2,
        S_MRD   = 4'd3,
        S_MWB   = 4'd4,
        S_MWR   = 4'd5,
        S_REX   = 4'd6,
        S_RWB   = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9,
        S_IEX   = 4'd10,
        S_IWB   = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control.sv
// Multi-cycle MIPS-style control FSM: state register, opcode latch, next-state
// logic and a Moore output decoder (IF write strobes also follow i_memready).
module mc_control
    import mc_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] i_instr,
    // Memory handshake: a transfer started in IF/MRD/MWR completes in the cycle
    // i_memready is high; the FSM holds its state (and its strobes) until then.
    input  logic       i_memready,
    output logic       o_pcwrite,
    output logic       o_pcwritecond,
    output logic       o_iord,
    output logic       o_memread,
    output logic       o_memwrite,
    output logic       o_memtoreg,
    output logic       o_irwrite,
    output logic       o_alusrca,
    output logic       o_regwrite,
    output logic       o_regdst,
    output logic       o_selectzero,
    output logic [1:0] o_pcsource,
    output logic [1:0] o_aluop,
    output logic [1:0] o_alusrcb,
    output logic [3:0] o_state,
    output logic       o_illegal
);

    state_e     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic       illegal_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IF;
            opcode_q <= 6'b000000;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        illegal_id = 1'b0;
        case (state_q)
            S_IF:    if (i_memready) state_d = S_ID;
            S_ID: begin
                // Decode from the live opcode; the latched copy steers later states.
                opcode_d = i_instr;
                case (i_instr)
                    OP_LW, OP_SW:   state_d = S_MADDR;
                    OP_R:           state_d = S_REX;
                    OP_BEQ, OP_BNE: state_d = S_BR;
                    OP_J:           state_d = S_JMP;
                    OP_ADDI:        state_d = S_IEX;
                    default: begin
                        state_d    = S_IF;
                        illegal_id = 1'b1;
                    end
                endcase
            end
            S_MADDR: state_d = (opcode_q == OP_SW) ? S_MWR : S_MRD;
            S_MRD:   if (i_memready) state_d = S_MWB;
            S_MWB:   state_d = S_IF;
            S_MWR:   if (i_memready) state_d = S_IF;
            S_REX:   state_d = S_RWB;
            S_RWB:   state_d = S_IF;
            S_BR:    state_d = S_IF;
            S_JMP:   state_d = S_IF;
            S_IEX:   state_d = S_IWB;
            S_IWB:   state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        o_pcwrite     = 1'b0;
        o_pcwritecond = 1'b0;
        o_iord        = 1'b0;
        o_memread     = 1'b0;
        o_memwrite    = 1'b0;
        o_memtoreg    = 1'b0;
        o_irwrite     = 1'b0;
        o_alusrca     = 1'b0;
        o_regwrite    = 1'b0;
        o_regdst      = 1'b0;
        o_selectzero  = 1'b0;
        o_pcsource    = PCSRC_ALU;
        o_aluop       = ALUOP_ADD;
        o_alusrcb     = SRCB_REGB;
        o_illegal     = 1'b0;
        o_state       = 4'd0;
        if (!rst) begin
            o_state   = state_q;
            o_illegal = illegal_id;
            case (state_q)
                S_IF: begin
                    o_memread = 1'b1;
                    o_alusrcb = SRCB_FOUR;
                    o_irwrite = i_memready;
                    o_pcwrite = i_memready;
                end
                S_ID:    o_alusrcb = SRCB_IMM_SH2;
                S_MADDR: begin
                    o_alusrca = 1'b1;
                    o_alusrcb = SRCB_IMM;
                end
                S_MRD: begin
                    o_memread = 1'b1;
                    o_iord    = 1'b1;
                end
                S_MWB: begin
                    o_regwrite = 1'b1;
                    o_memtoreg = 1'b1;
                end
                S_MWR: begin
                    o_memwrite = 1'b1;
                    o_iord     = 1'b1;
                end
                S_REX: begin
                    o_alusrca = 1'b1;
                    o_aluop   = ALUOP_FUNCT;
                end
                S_RWB: begin
                    o_regwrite = 1'b1;
                    o_regdst   = 1'b1;
                end
                S_BR: begin
                    o_alusrca     = 1'b1;
                    o_aluop       = ALUOP_SUB;
                    o_pcwritecond = 1'b1;
                    o_pcsource    = PCSRC_ALUOUT;
                    o_selectzero  = (opcode_q == OP_BNE);
                end
                S_JMP: begin
                    o_pcwrite  = 1'b1;
                    o_pcsource = PCSRC_JUMP;
                end
                S_IEX: begin
                    o_alusrca = 1'b1;
                    o_alusrcb = SRCB_IMM;
                end
                S_IWB:   o_regwrite = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each instruction class through the FSM
// and compares state plus the packed control word against hand-built vectors.
module tb_mc_control;

    logic       clk;
    logic       rst;
    logic [5:0] i_instr;
    logic       i_memready;
    logic       o_pcwrite, o_pcwritecond, o_iord, o_memread, o_memwrite;
    logic       o_memtoreg, o_irwrite, o_alusrca, o_regwrite, o_regdst, o_selectzero;
    logic [1:0] o_pcsource, o_aluop, o_alusrcb;
    logic [3:0] o_state;
    logic       o_illegal;

    int errors = 0;
    int checks = 0;

    // Control word: pw pwc iord mr mw mtr irw asa rw rd sz | pcsrc | aluop | srcb
    logic [16:0] ctl;
    assign ctl = {o_pcwrite, o_pcwritecond, o_iord, o_memread, o_memwrite,
                  o_memtoreg, o_irwrite, o_alusrca, o_regwrite, o_regdst,
                  o_selectzero, o_pcsource, o_aluop, o_alusrcb};

    localparam logic [16:0] C_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_IF_RDY = 17'b1_0_0_1_0_0_1_0_0_0_0_00_00_01;
    localparam logic [16:0] C_IF_WT  = 17'b0_0_0_1_0_0_0_0_0_0_0_00_00_01;
    localparam logic [16:0] C_ID     = 17'b0_0_0_0_0_0_0_0_0_0_0_00_00_11;
    localparam logic [16:0] C_MADDR  = 17'b0_0_0_0_0_0_0_1_0_0_0_00_00_10;
    localparam logic [16:0] C_MRD    = 17'b0_0_1_1_0_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_MWB    = 17'b0_0_0_0_0_1_0_0_1_0_0_00_00_00;
    localparam logic [16:0] C_MWR    = 17'b0_0_1_0_1_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_REX    = 17'b0_0_0_0_0_0_0_1_0_0_0_00_10_00;
    localparam logic [16:0] C_RWB    = 17'b0_0_0_0_0_0_0_0_1_1_0_00_00_00;
    localparam logic [16:0] C_BNE    = 17'b0_1_0_0_0_0_0_1_0_0_1_01_01_00;
    localparam logic [16:0] C_BEQ    = 17'b0_1_0_0_0_0_0_1_0_0_0_01_01_00;
    localparam logic [16:0] C_JMP    = 17'b1_0_0_0_0_0_0_0_0_0_0_10_00_00;
    localparam logic [16:0] C_IEX    = 17'b0_0_0_0_0_0_0_1_0_0_0_00_00_10;
    localparam logic [16:0] C_IWB    = 17'b0_0_0_0_0_0_0_0_1_0_0_00_00_00;

    mc_control dut (
        .clk          (clk),
        .rst          (rst),
        .i_instr      (i_instr),
        .i_memready   (i_memready),
        .o_pcwrite    (o_pcwrite),
        .o_pcwritecond(o_pcwritecond),
        .o_iord       (o_iord),
        .o_memread    (o_memread),
        .o_memwrite   (o_memwrite),
        .o_memtoreg   (o_memtoreg),
        .o_irwrite    (o_irwrite),
        .o_alusrca    (o_alusrca),
        .o_regwrite   (o_regwrite),
        .o_regdst     (o_regdst),
        .o_selectzero (o_selectzero),
        .o_pcsource   (o_pcsource),
        .o_aluop      (o_aluop),
        .o_alusrcb    (o_alusrcb),
        .o_state      (o_state),
        .o_illegal    (o_illegal)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        i_instr    = 6'b000000;
        i_memready = 1'b1;
        tick();
        tick();
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0", o_state);
        end
        checks++;
        if (ctl !== C_ZERO || o_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b ill=%b want %b ill=0", ctl, o_illegal, C_ZERO);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (o_state !== 4'd0 || ctl !== C_IF_RDY) begin
            errors++;
            $display("FAIL reset_release_if: state=%0d ctl=%b want 0 %b", o_state, ctl, C_IF_RDY);
        end
    endtask

    task automatic test_lw();
        logic [3:0]  exp_q[$];
        logic [16:0] exp_c[$];
        logic [3:0]  es;
        logic [16:0] ec;
        exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        exp_c = '{C_ID, C_MADDR, C_MRD, C_MWB, C_IF_RDY};
        i_instr = 6'b100011;
        while (exp_q.size() > 0) begin
            tick();
            es = exp_q.pop_front();
            ec = exp_c.pop_front();
            checks++;
            if (o_state !== es || ctl !== ec) begin
                errors++;
                $display("FAIL lw_seq: state=%0d ctl=%b want %0d %b", o_state, ctl, es, ec);
            end
        end
    endtask

    task automatic test_sw_wait();
        i_instr = 6'b101011;
        tick();
        tick();
        i_memready = 1'b0;
        checks++;
        if (o_state !== 4'd2 || ctl !== C_MADDR) begin
            errors++;
            $display("FAIL sw_maddr: state=%0d ctl=%b want 2 %b", o_state, ctl, C_MADDR);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) i_memready = 1'b1;
            checks++;
            if (o_state !== 4'd5 || ctl !== C_MWR) begin
                errors++;
                $display("FAIL sw_hold%0d: state=%0d ctl=%b want 5 %b", i, o_state, ctl, C_MWR);
            end
        end
        tick();
        checks++;
        if (o_state !== 4'd0 || o_regwrite !== 1'b0) begin
            errors++;
            $display("FAIL sw_done: state=%0d regwrite=%b want 0 0", o_state, o_regwrite);
        end
    endtask

    task automatic test_branch(input logic [5:0] op, input logic [16:0] exp_br);
        i_instr = op;
        tick();
        tick();
        checks++;
        if (o_state !== 4'd8 || ctl !== exp_br) begin
            errors++;
            $display("FAIL branch_%b: state=%0d ctl=%b want 8 %b", op, o_state, ctl, exp_br);
        end
        tick();
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("FAIL branch_ret_%b: state=%0d want 0", op, o_state);
        end
    endtask

    task automatic test_illegal();
        i_instr = 6'b111111;
        tick();
        checks++;
        if (o_state !== 4'd1 || o_illegal !== 1'b1 || ctl !== C_ID) begin
            errors++;
            $display("FAIL illegal_id: state=%0d ill=%b ctl=%b want 1 1 %b", o_state, o_illegal, ctl, C_ID);
        end
        tick();
        checks++;
        if (o_state !== 4'd0 || o_illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_next: state=%0d ill=%b want 0 0", o_state, o_illegal);
        end
    endtask

    task automatic test_reset_in_mrd();
        i_instr = 6'b100011;
        tick();
        tick();
        i_memready = 1'b0;
        tick();
        tick();
        checks++;
        if (o_state !== 4'd3 || ctl !== C_MRD) begin
            errors++;
            $display("FAIL mrd_hold: state=%0d ctl=%b want 3 %b", o_state, ctl, C_MRD);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (o_state !== 4'd0 || ctl !== C_ZERO) begin
            errors++;
            $display("FAIL mrd_rst_outputs: state=%0d ctl=%b want 0 %b", o_state, ctl, C_ZERO);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (o_state !== 4'd0 || ctl !== C_IF_WT) begin
            errors++;
            $display("FAIL mrd_rst_after: state=%0d ctl=%b want 0 %b", o_state, ctl, C_IF_WT);
        end
        tick();
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("FAIL if_wait: state=%0d want 0", o_state);
        end
        i_memready = 1'b1;
    endtask

    task automatic test_rtype_instr_change();
        i_instr = 6'b000000;
        tick();
        tick();
        checks++;
        if (o_state !== 4'd6 || ctl !== C_REX) begin
            errors++;
            $display("FAIL rex: state=%0d ctl=%b want 6 %b", o_state, ctl, C_REX);
        end
        i_instr = 6'b000010;
        tick();
        checks++;
        if (o_state !== 4'd7 || ctl !== C_RWB) begin
            errors++;
            $display("FAIL rwb: state=%0d ctl=%b want 7 %b", o_state, ctl, C_RWB);
        end
        tick();
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("FAIL rtype_ret: state=%0d want 0", o_state);
        end
    endtask

    task automatic test_jump();
        i_instr = 6'b000010;
        tick();
        tick();
        checks++;
        if (o_state !== 4'd9 || ctl !== C_JMP) begin
            errors++;
            $display("FAIL jmp: state=%0d ctl=%b want 9 %b", o_state, ctl, C_JMP);
        end
        tick();
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("FAIL jmp_ret: state=%0d want 0", o_state);
        end
    endtask

    task automatic test_addi();
        i_instr = 6'b001000;
        tick();
        tick();
        checks++;
        if (o_state !== 4'd10 || ctl !== C_IEX) begin
            errors++;
            $display("FAIL iex: state=%0d ctl=%b want 10 %b", o_state, ctl, C_IEX);
        end
        tick();
        checks++;
        if (o_state !== 4'd11 || ctl !== C_IWB) begin
            errors++;
            $display("FAIL iwb: state=%0d ctl=%b want 11 %b", o_state, ctl, C_IWB);
        end
        tick();
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("FAIL addi_ret: state=%0d want 0", o_state);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_branch(6'b000101, C_BNE);
        test_branch(6'b000100, C_BEQ);
        test_illegal();
        test_reset_in_mrd();
        test_rtype_instr_change();
        test_jump();
        test_addi();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
